// File: rtl/t_down_counter_pkg.sv
// Shared definitions for the T flip-flop down-counter/timer.
//   state_e       : controller state encoding (ST_IDLE / ST_RUN)
//   DEFAULT_WIDTH : default counter width in bits
package t_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/t_down_counter_t_ff_sync.sv
// Single T flip-flop with synchronous active-high reset and synchronous load.
// Ports:
//   CLK   : rising-edge clock
//   Reset : synchronous active-high reset (highest priority), clears Q
//   Load  : synchronous load of D (above toggle)
//   D     : load value
//   T     : toggle enable
//   Q     : flip-flop output
module t_ff_sync (
    input  logic CLK,
    input  logic Reset,
    input  logic Load,
    input  logic D,
    input  logic T,
    output logic Q
);

    logic q_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_q <= 1'b0;
        end else if (Load) begin
            q_q <= D;
        end else if (T) begin
            q_q <= ~q_q;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/t_down_counter.sv
// Loadable down-counter/timer built from T flip-flops, with optional
// auto-reload for periodic ticks.
// Ports:
//   CLK        : rising-edge clock
//   Reset      : synchronous active-high reset (overrides Load and T)
//   Load       : load D into counter and reload register, start a run
//   D          : start/reload value
//   T          : count enable in RUN
//   AutoReload : 1 = reload on terminal count, 0 = one-shot
//   Q          : current count
//   Zero       : combinational Q == 0
//   Busy       : registered, high while in RUN
//   Done       : registered one-cycle terminal-count pulse
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | counter holds, T ignored
// ST_RUN  | counting down on T, Q is never 0 here
module t_down_counter
    import t_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             T,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    logic             cnt_en;
    logic             term_cnt;
    logic             ff_load;
    logic [WIDTH-1:0] ff_d;
    logic [WIDTH-1:0] tog;

    // The Q != 0 term guards against a wrap to all-ones even if RUN were
    // somehow entered with a zero count.
    assign cnt_en   = (state_q == ST_RUN) && T && (Q != '0);
    assign term_cnt = cnt_en && (Q == WIDTH'(1));

    // An auto-reload at terminal count reuses the flip-flops' load path;
    // an external Load always takes the D value.
    assign ff_load  = Load || (term_cnt && AutoReload);
    assign ff_d     = Load ? D : reload_q;

    // Borrow chain: bit i toggles only when every lower bit is zero.
    always_comb begin
        tog    = '0;
        tog[0] = cnt_en;
        for (int i = 1; i < WIDTH; i++) begin
            tog[i] = tog[i-1] && !Q[i-1];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        t_ff_sync u_tff (
            .CLK   (CLK),
            .Reset (Reset),
            .Load  (ff_load),
            .D     (ff_d[g]),
            .T     (tog[g]),
            .Q     (Q[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (Load) begin
            reload_d = D;
            state_d  = (D != '0) ? ST_RUN : ST_IDLE;
        end else if (term_cnt) begin
            done_d = 1'b1;
            if (!AutoReload) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign Zero = (Q == '0);
    assign Busy = (state_q == ST_RUN);
    assign Done = done_q;

endmodule

// File: tb/tb_t_down_counter.sv
module tb_t_down_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] d;
    logic         t;
    logic         ar;
    logic [W-1:0] q;
    logic         zero;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: plain integer count, saved period, running flag.
    int m_q      = 0;
    int m_reload = 0;
    bit m_run    = 1'b0;
    bit m_done   = 1'b0;

    t_down_counter #(.WIDTH(W)) dut (
        .CLK        (clk),
        .Reset      (rst),
        .Load       (load),
        .D          (d),
        .T          (t),
        .AutoReload (ar),
        .Q          (q),
        .Zero       (zero),
        .Busy       (busy),
        .Done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input int dv, input bit tv, input bit av);
        if (r) begin
            m_q = 0; m_reload = 0; m_run = 0; m_done = 0;
        end else if (l) begin
            m_q = dv; m_reload = dv; m_run = (dv != 0); m_done = 0;
        end else if (m_run && tv) begin
            if (m_q == 1) begin
                m_done = 1;
                if (av) m_q = m_reload;
                else begin
                    m_q = 0; m_run = 0;
                end
            end else begin
                m_q = m_q - 1; m_done = 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    // Apply inputs, take one edge, then compare all outputs against the model.
    task automatic step(input bit r, input bit l, input int dv, input bit tv, input bit av, input string tag);
        rst = r; load = l; d = W'(dv); t = tv; ar = av;
        @(posedge clk);
        model_edge(r, l, dv, tv, av);
        #1;
        check({tag, ".Q"},    32'(q),    32'(m_q));
        check({tag, ".Zero"}, 32'(zero), 32'(m_q == 0));
        check({tag, ".Busy"}, 32'(busy), 32'(m_run));
        check({tag, ".Done"}, 32'(done), 32'(m_done));
    endtask

    initial begin
        int pulses;
        int cyc;
        int dv;
        rst = 1'b1; load = 1'b0; d = '0; t = 1'b0; ar = 1'b0;

        // Reset, then T with nothing loaded
        step(1, 0, 0, 1, 0, "rst0");
        step(1, 0, 0, 1, 0, "rst1");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "idle_t");

        // One-shot from 5, then hold at 0
        step(0, 1, 5, 1, 0, "ld5");
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, "oneshot");

        // Auto-reload period 3: expect 4 Done pulses in 12 enabled cycles
        step(0, 1, 3, 1, 1, "ld3");
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 1, "auto3");
            if (done) pulses++;
        end
        check("auto3.pulses", 32'(pulses), 32'd4);
        check("auto3.busy",   32'(busy),   32'd1);

        // 0x80 with T toggling; the 0x80 -> 0x7F edge flips every bit
        step(0, 1, 'h80, 0, 0, "ld80");
        step(0, 0, 0, 0, 0, "pause80");
        step(0, 0, 0, 1, 0, "dec80");
        check("borrow.7F", 32'(q), 32'h7F);
        for (int i = 0; i < 8; i++) step(0, 0, 0, i % 2, 0, "tgl");

        // Load on the terminal-count edge wins and suppresses Done
        step(0, 1, 4, 1, 0, "ld4");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "to1");
        check("tc.q_is_1", 32'(q), 32'd1);
        step(0, 1, 9, 1, 0, "ld9_tc");
        check("tc.nodone", 32'(done), 32'd0);
        step(0, 0, 0, 1, 0, "run9");
        step(1, 1, 7, 1, 0, "rst_ld");

        // Zero load stays idle; full-range load takes 255 enabled cycles
        step(0, 1, 0, 1, 0, "ld0");
        step(0, 0, 0, 1, 0, "ld0_t");
        step(0, 1, 'hFF, 1, 0, "ldFF");
        cyc = 0;
        while (cyc < 300) begin
            step(0, 0, 0, 1, 0, "runFF");
            cyc++;
            if (done) break;
        end
        check("full.cycles", 32'(cyc), 32'd255);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 6));
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 11) == 0),
                 dv,
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_down_counter.md
Name: t_down_counter

Overview:
- Loadable down-counter/timer built from T flip-flops; the count-down counterpart of the team's 8-bit T flip-flop up-counter.
- Load a start value, decrement on each enabled clock, flag terminal count with a one-cycle Done pulse.
- Optional auto-reload gives a periodic tick.
- Sits beside the up-counter in the registers/counters library; used as a programmable delay and interval timer.

Parameters:
WIDTH, 8, counter width in bits (≥2)

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Load  input  1  load D into counter and reload register; starts a run
D  input  WIDTH  start/reload value
T  input  1  count enable; decrement by 1 when high in RUN
AutoReload  input  1  1 = reload from reload register on terminal count; 0 = one-shot
Q  output  WIDTH  current count
Zero  output  1  combinational, Q == 0
Busy  output  1  registered, high while in RUN
Done  output  1  registered, one-cycle terminal-count pulse

Behaviour:
- Interface: one clock, CLK; reset Reset is synchronous and active-high, sampled only on rising CLK.
- Reset: Q=0, reload reg=0, state IDLE, Busy=0, Done=0, Zero=1. Reset overrides Load and T in the same cycle.
- States: IDLE, RUN. Busy = (state == RUN).
- Priority each edge: Reset > Load > count.
- Load=1 (any state): Q<=D, reload<=D, Done<=0.
  - D!=0: next state RUN.
  - D==0: next state IDLE; no Done.
  - Load in RUN restarts the run cleanly. Load on a terminal-count cycle wins and suppresses Done.
- RUN, T=0: Q holds, Done<=0 (pause).
- RUN, T=1, Q>1: Q<=Q-1, Done<=0.
  - Bit 0 toggles.
  - Bit i toggles iff T and Q[i-1:0] are all zero (borrow chain).
- RUN, T=1, Q==1 (terminal count): Done<=1 for exactly one cycle.
  - AutoReload=0: Q<=0, next state IDLE.
  - AutoReload=1: Q<=reload, stay RUN. Q never shows 0, so period = reload value cycles. Reload=1 gives Done every enabled cycle.
- AutoReload is sampled at the terminal-count edge only.
- IDLE: T ignored, Q holds. No underflow/wrap from 0 to all-ones under any input.
- Latency: Q updates on the edge where Load or T is sampled. Done is high in the cycle immediately after the terminal-count edge.
- Q == {WIDTH{1}} load is legal: full 2^WIDTH-1 cycle run.
- No X on outputs after the first Reset edge.

Decomposition:
- Shared package/header: state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1; default WIDTH.
- Sub-module t_ff_sync: one T flip-flop with synchronous active-high reset and synchronous load (ports CLK, Reset, Load, D, T, Q). Generate WIDTH instances.
- Top holds the FSM, reload register, toggle-enable chain and Done register.

Test Plan:
- Reset high 2 cycles, then low, T=1 -> Q=0, Zero=1, Busy=0, Done never asserts.
- Load D=5, AutoReload=0, T=1 continuous -> Q: 5,4,3,2,1,0; Done high one cycle as Q reaches 0; Busy falls the same edge; Q stays 0 for 10 more cycles.
- Load D=3, AutoReload=1, T=1 for 12 cycles -> Q: 3,2,1,3,2,1,…; Done pulses every 3rd cycle, 4 pulses total; Busy stays 1.
- Load D=8'h80, T toggling 1/0 -> Q decrements only on T=1 cycles; 8'h80→8'h7F flips all 8 bits in one edge.
- Load D=4, count to Q=1, then assert Load D=9 with T=1 on the terminal edge -> Q=9, no Done; Reset asserted with Load=1 mid-run -> Q=0, Busy=0.
- Load D=0 -> Q=0, Busy=0, Done=0; Load D=8'hFF, AutoReload=0 -> exactly 255 enabled cycles to Done.
